// File: rtl/result_display_scanner_pkg.sv
// Shared definitions for the result display scanner: FSM states, BCD width and
// the active-low seven-segment code table {g,f,e,d,c,b,a}.
package result_display_scanner_pkg;

    localparam int unsigned BCD_W = 40;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CONVERT,
        S_SHOW,
        S_ADVANCE
    } state_t;

    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        case (digit)
            4'd0: seg_code = 7'h40;
            4'd1: seg_code = 7'h79;
            4'd2: seg_code = 7'h24;
            4'd3: seg_code = 7'h30;
            4'd4: seg_code = 7'h19;
            4'd5: seg_code = 7'h12;
            4'd6: seg_code = 7'h02;
            4'd7: seg_code = 7'h78;
            4'd8: seg_code = 7'h00;
            4'd9: seg_code = 7'h10;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/result_display_scanner_bin2bcd_seq.sv
// Iterative double-dabble: 32-bit unsigned binary to 10 BCD digits, one bit per
// cycle. done pulses for one cycle once all 32 bits have been shifted in.
module bin2bcd_seq
    import result_display_scanner_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    logic [31:0]      shift;
    logic [4:0]       cnt;
    logic [BCD_W-1:0] adj;

    always_comb begin
        adj = bcd;
        for (int unsigned i = 0; i < BCD_W / 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // a restart abandons any conversion still in flight
                shift <= bin;
                bcd   <= '0;
                cnt   <= '0;
                busy  <= 1'b1;
            end else if (busy) begin
                bcd   <= {adj[BCD_W-2:0], shift[31]};
                shift <= {shift[30:0], 1'b0};
                cnt   <= cnt + 5'd1;
                if (cnt == 5'd31) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/result_display_scanner.sv
// Walks 32 registers then 32 data-memory words after halt, showing each value as
// five decimal seven-segment digits; advanced by a debounced button or auto timer.
module result_display_scanner
    import result_display_scanner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned AUTO_PERIOD     = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        btn_next,
    output logic [4:0]  rd_addr,
    output logic        rd_is_mem,
    input  logic [31:0] rd_data,
    output logic [5:0]  idx_led,
    output logic        ovf,
    output logic [6:0]  display1,
    output logic [6:0]  display2,
    output logic [6:0]  display3,
    output logic [6:0]  display4,
    output logic [6:0]  display5
);

    localparam int unsigned DB_W      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned DW_W      = $clog2(AUTO_PERIOD + 1) + 1;
    localparam int unsigned AUTO_LAST = (AUTO_PERIOD == 0) ? 0 : AUTO_PERIOD - 1;

    state_t           state, next_state;
    logic             sync1, sync2, level, level_d, step;
    logic [DB_W-1:0]  db_cnt;
    logic [DW_W-1:0]  dwell;
    logic             auto_expire;
    logic [5:0]       ptr;
    logic             conv_start, conv_busy, conv_done;
    logic [BCD_W-1:0] conv_bcd;

    assign rd_addr   = ptr[4:0];
    assign rd_is_mem = ptr[5];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            db_cnt  <= '0;
        end else begin
            sync1   <= btn_next;
            sync2   <= sync1;
            level_d <= level;
            if (sync2 == level)
                db_cnt <= '0;
            else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                level  <= sync2;
                db_cnt <= '0;
            end else
                db_cnt <= db_cnt + DB_W'(1);
        end
    end

    assign step        = level & ~level_d;
    assign auto_expire = (AUTO_PERIOD != 0) && (dwell == DW_W'(AUTO_LAST));

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (rd_data),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        conv_start = 1'b0;
        if (!halt)
            next_state = S_IDLE;
        else begin
            case (state)
                S_IDLE:    next_state = S_FETCH;
                S_FETCH: begin
                    conv_start = 1'b1;
                    next_state = S_CONVERT;
                end
                // an idle converter without done means the run was lost; refetch
                S_CONVERT: begin
                    if (conv_done)       next_state = S_SHOW;
                    else if (!conv_busy) next_state = S_FETCH;
                end
                S_SHOW:    if (step || auto_expire) next_state = S_ADVANCE;
                S_ADVANCE: next_state = S_FETCH;
                default:   next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !halt) begin
            ptr      <= '0;
            dwell    <= '0;
            idx_led  <= '0;
            ovf      <= 1'b0;
            display1 <= SEG_BLANK;
            display2 <= SEG_BLANK;
            display3 <= SEG_BLANK;
            display4 <= SEG_BLANK;
            display5 <= SEG_BLANK;
        end else begin
            case (state)
                S_CONVERT: begin
                    if (conv_done) begin
                        display1 <= seg_code(conv_bcd[3:0]);
                        display2 <= seg_code(conv_bcd[7:4]);
                        display3 <= seg_code(conv_bcd[11:8]);
                        display4 <= seg_code(conv_bcd[15:12]);
                        display5 <= seg_code(conv_bcd[19:16]);
                        ovf      <= |conv_bcd[BCD_W-1:20];
                        idx_led  <= ptr;
                        dwell    <= '0;
                    end
                end
                S_SHOW:    dwell <= dwell + DW_W'(1);
                S_ADVANCE: ptr <= ptr + 6'd1;
                default: ;
            endcase
        end
    end

endmodule
